// File: rtl/axi3_pkg.sv
// axi3_pkg: shared AXI3 encodings, read-arbiter state and AR payload types, burst legality check.
package axi3_pkg;
    localparam logic [2:0] XSIZE_1   = 3'd0;
    localparam logic [2:0] XSIZE_2   = 3'd1;
    localparam logic [2:0] XSIZE_4   = 3'd2;
    localparam logic [2:0] XSIZE_8   = 3'd3;
    localparam logic [2:0] XSIZE_16  = 3'd4;
    localparam logic [2:0] XSIZE_32  = 3'd5;
    localparam logic [2:0] XSIZE_64  = 3'd6;
    localparam logic [2:0] XSIZE_128 = 3'd7;
    localparam logic [1:0] XBURST_FIXED    = 2'd0;
    localparam logic [1:0] XBURST_INCR     = 2'd1;
    localparam logic [1:0] XBURST_WRAP     = 2'd2;
    localparam logic [1:0] XBURST_RESERVED = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    localparam logic [2:0] XPROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] XPROT_NONSECURE   = 3'b010;
    localparam logic [2:0] XPROT_INSTRUCTION = 3'b100;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} arb_state_t;

    // addr is sized for the widest bus any arbiter instance may use
    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  prot;
    } ar_payload_t;

    function automatic logic burst_legal(ar_payload_t p, int dw);
        logic ok;
        int bytes;
        bytes = 1 << p.size;
        ok = (p.burst != XBURST_RESERVED) && (bytes <= dw / 8);
        if (p.burst == XBURST_WRAP)
            ok = ok && (p.len inside {4'd1, 4'd3, 4'd7, 4'd15})
                    && ((p.addr & 64'(bytes - 1)) == 64'd0);
        return ok;
    endfunction
endpackage

// File: rtl/axi3_rr_picker.sv
// axi3_rr_picker: first asserted request at or above ptr, wrapping; one-hot grant plus index.
module axi3_rr_picker #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);
    always_comb begin
        int j;
        j = 0;
        grant = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any = 1'b1;
                grant[j] = 1'b1;
                idx = PW'(j);
            end
        end
    end
endmodule

// File: rtl/axi3_rd_arbiter.sv
// axi3_rd_arbiter: round-robin sharing of one AXI3 read port among NREQ requesters,
// one burst outstanding; illegal bursts are answered locally with SLVERR beats.
module axi3_rd_arbiter
    import axi3_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 64,
    parameter int IDW  = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [NREQ-1:0]   req_arvalid,
    input  logic [NREQ*AW-1:0] req_araddr,
    input  logic [NREQ*4-1:0] req_arlen,
    input  logic [NREQ*3-1:0] req_arsize,
    input  logic [NREQ*2-1:0] req_arburst,
    input  logic [NREQ*3-1:0] req_arprot,
    output logic [NREQ-1:0]   req_arready,
    output logic [NREQ-1:0]   req_rvalid,
    input  logic [NREQ-1:0]   req_rready,
    output logic [DW-1:0]     req_rdata,
    output logic [1:0]        req_rresp,
    output logic              req_rlast,
    output logic [IDW-1:0]    ARID,
    output logic [AW-1:0]     ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic [2:0]        ARPROT,
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic [3:0]        ARCACHE,
    input  logic [IDW-1:0]    RID,
    input  logic [DW-1:0]     RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY
);
    localparam int PW = $clog2(NREQ);

    arb_state_t      state, state_d;
    logic [PW-1:0]   rr_ptr, rr_ptr_d, g, g_d, g_next, pick_idx;
    logic [NREQ-1:0] pick_grant;
    logic            pick_any;
    ar_payload_t     cand;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      len_q, len_d, cnt, cnt_d;
    logic [2:0]      size_q, size_d, prot_q, prot_d;
    logic [1:0]      burst_q, burst_d;
    logic            rid_err, rid_err_d, last_err, last_err_d;

    axi3_rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (req_arvalid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        cand       = '0;
        cand.addr  = 64'(req_araddr[int'(pick_idx)*AW +: AW]);
        cand.len   = req_arlen[int'(pick_idx)*4 +: 4];
        cand.size  = req_arsize[int'(pick_idx)*3 +: 3];
        cand.burst = req_arburst[int'(pick_idx)*2 +: 2];
        cand.prot  = req_arprot[int'(pick_idx)*3 +: 3];
    end

    assign g_next  = (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
    assign ARVALID = state == ADDR;
    assign ARID    = IDW'(g);
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = size_q;
    assign ARBURST = burst_q;
    assign ARPROT  = prot_q;
    assign ARCACHE = 4'b0000;

    always_comb begin
        state_d = state;
        rr_ptr_d = rr_ptr;
        g_d = g;
        addr_d = addr_q;
        len_d = len_q;
        size_d = size_q;
        burst_d = burst_q;
        prot_d = prot_q;
        cnt_d = cnt;
        rid_err_d = rid_err;
        last_err_d = last_err;
        req_arready = '0;
        req_rvalid = '0;
        req_rdata = '0;
        req_rresp = RESP_OKAY;
        req_rlast = 1'b0;
        RREADY = 1'b0;
        case (state)
            IDLE: if (pick_any && !ARESET) begin
                req_arready = pick_grant;
                g_d = pick_idx;
                addr_d = cand.addr[AW-1:0];
                len_d = cand.len;
                size_d = cand.size;
                burst_d = cand.burst;
                prot_d = cand.prot;
                cnt_d = '0;
                state_d = burst_legal(cand, DW) ? ADDR : ERR;
            end
            ADDR: if (ARREADY) state_d = DATA;
            DATA: begin
                RREADY = req_rready[g];
                req_rvalid[g] = RVALID;
                req_rdata = RDATA;
                req_rresp = RRESP;
                req_rlast = RLAST;
                if (RVALID && RID != IDW'(g)) rid_err_d = 1'b1;
                // the slave's RLAST ends the burst even when the count disagrees
                if (RVALID && req_rready[g]) begin
                    if (RLAST != (cnt == len_q)) last_err_d = 1'b1;
                    if (cnt != len_q) cnt_d = cnt + 4'd1;
                    if (RLAST) begin
                        state_d = IDLE;
                        rr_ptr_d = g_next;
                        cnt_d = '0;
                    end
                end
            end
            ERR: begin
                req_rvalid[g] = 1'b1;
                req_rresp = RESP_SLVERR;
                req_rlast = cnt == len_q;
                if (req_rready[g]) begin
                    cnt_d = cnt + 4'd1;
                    if (cnt == len_q) begin
                        state_d = IDLE;
                        rr_ptr_d = g_next;
                        cnt_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
            rr_ptr <= '0;
            g <= '0;
            addr_q <= '0;
            len_q <= '0;
            size_q <= '0;
            burst_q <= '0;
            prot_q <= '0;
            cnt <= '0;
            rid_err <= 1'b0;
            last_err <= 1'b0;
        end else begin
            state <= state_d;
            rr_ptr <= rr_ptr_d;
            g <= g_d;
            addr_q <= addr_d;
            len_q <= len_d;
            size_q <= size_d;
            burst_q <= burst_d;
            prot_q <= prot_d;
            cnt <= cnt_d;
            rid_err <= rid_err_d;
            last_err <= last_err_d;
        end
    end
endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb_axi3_rd_arbiter: directed bench for the round-robin AXI3 read arbiter.
module tb_axi3_rd_arbiter;
    import axi3_pkg::*;
    localparam int NREQ = 2, AW = 32, DW = 64, IDW = 4;

    logic ACLK = 1'b0, ARESET;
    logic [NREQ-1:0] req_arvalid, req_arready, req_rvalid, req_rready;
    logic [NREQ*AW-1:0] req_araddr;
    logic [NREQ*4-1:0] req_arlen;
    logic [NREQ*3-1:0] req_arsize, req_arprot;
    logic [NREQ*2-1:0] req_arburst;
    logic [DW-1:0] req_rdata;
    logic [1:0] req_rresp;
    logic req_rlast;
    logic [IDW-1:0] ARID, RID;
    logic [AW-1:0] ARADDR;
    logic [3:0] ARLEN, ARCACHE;
    logic [2:0] ARSIZE, ARPROT;
    logic [1:0] ARBURST, RRESP;
    logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [DW-1:0] RDATA;
    int vectors = 0, miscompares = 0;

    always #5 ACLK = ~ACLK;

    axi3_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arsize(req_arsize), .req_arburst(req_arburst), .req_arprot(req_arprot),
        .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rready(req_rready),
        .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARCACHE(ARCACHE),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ACLK);
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [3:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        req_arvalid[i] = v;
        req_araddr[i*AW +: AW] = a;
        req_arlen[i*4 +: 4] = l;
        req_arsize[i*3 +: 3] = s;
        req_arburst[i*2 +: 2] = b;
        req_arprot[i*3 +: 3] = XPROT_NONSECURE;
    endtask

    initial begin
        ARESET = 1'b1;
        req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_arsize = '0;
        req_arburst = '0; req_arprot = '0; req_rready = '0;
        ARREADY = 0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
        repeat (3) cyc();
        ARESET = 1'b0;
        cyc();
        #1;
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        chk("rst_arvalid", 64'(ARVALID), 0);
        chk("rst_arready", 64'(req_arready), 0);
        chk("rst_arcache", 64'(ARCACHE), 0);

        // INCR burst, slave accepts address on the third ADDR cycle
        set_req(0, 1, 32'h1000, 4'd3, XSIZE_8, XBURST_INCR);
        #1 chk("t2_arready", 64'(req_arready), 2'b01);
        cyc(); req_arvalid[0] = 0;
        #1 chk("t2_arvalid1", 64'(ARVALID), 1);
        chk("t2_arid", 64'(ARID), 0);
        chk("t2_araddr", 64'(ARADDR), 32'h1000);
        chk("t2_arlen", 64'(ARLEN), 3);
        chk("t2_arprot", 64'(ARPROT), XPROT_NONSECURE);
        chk("t2_arready_addr", 64'(req_arready), 0);
        cyc(); #1 chk("t2_arvalid2", 64'(ARVALID), 1);
        cyc(); ARREADY = 1;
        #1 chk("t2_arvalid3", 64'(ARVALID), 1);
        cyc(); ARREADY = 0;
        RVALID = 1; RID = 0; RDATA = 64'h100; RLAST = 0; req_rready = 2'b01;
        #1 chk("t2_ar_drop", 64'(ARVALID), 0);
        chk("t2_rvalid", 64'(req_rvalid), 2'b01);
        chk("t2_rdata0", req_rdata, 64'h100);
        chk("t2_rready", 64'(RREADY), 1);
        cyc(); RDATA = 64'h101; req_rready = 2'b00;
        #1 chk("t2_bp_rready", 64'(RREADY), 0);
        chk("t2_bp_rvalid", 64'(req_rvalid), 2'b01);
        cyc(); req_rready = 2'b01;
        #1 chk("t2_rdata1", req_rdata, 64'h101);
        cyc(); RDATA = 64'h102;
        #1 chk("t2_rlast2", 64'(req_rlast), 0);
        cyc(); RDATA = 64'h103; RLAST = 1;
        #1 chk("t2_rdata3", req_rdata, 64'h103);
        chk("t2_rlast3", 64'(req_rlast), 1);
        cyc(); RVALID = 0; RLAST = 0;
        #1 chk("t2_idle", 64'(dut.state), 64'(IDLE));
        chk("t2_rrptr", 64'(dut.rr_ptr), 1);
        chk("t6_rid_err0", 64'(dut.rid_err), 0);

        // wrong RID during grant 0, then reset mid-DATA
        set_req(0, 1, 32'h1800, 4'd1, XSIZE_8, XBURST_INCR);
        #1 chk("t6_arready", 64'(req_arready), 2'b01);
        cyc(); req_arvalid[0] = 0; ARREADY = 1;
        #1 chk("t6_arid", 64'(ARID), 0);
        cyc(); ARREADY = 0; RVALID = 1; RID = 1; RDATA = 64'h55;
        #1 chk("t6_rvalid", 64'(req_rvalid), 2'b01);
        chk("t6_rdata", req_rdata, 64'h55);
        cyc(); req_rready = 2'b00;
        #1 chk("t6_rid_err", 64'(dut.rid_err), 1);
        chk("t6_bp_rready", 64'(RREADY), 0);
        req_rready = 2'b01; ARESET = 1;
        cyc(); #1;
        chk("t1_rready", 64'(RREADY), 0);
        chk("t1_rvalid", 64'(req_rvalid), 0);
        chk("t1_arvalid", 64'(ARVALID), 0);
        chk("t1_araddr", 64'(ARADDR), 0);
        chk("t1_state", 64'(dut.state), 64'(IDLE));
        chk("t1_rrptr", 64'(dut.rr_ptr), 0);
        chk("t1_rid_err", 64'(dut.rid_err), 0);
        RVALID = 0; RID = 0; ARESET = 0; req_rready = 2'b11;
        cyc();

        // both requesters always waiting: grants must alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            int e;
            e = k % 2;
            set_req(0, 1, 32'h2000, 4'd0, XSIZE_8, XBURST_INCR);
            set_req(1, 1, 32'h2100, 4'd0, XSIZE_8, XBURST_INCR);
            #1 chk("t3_grant", 64'(req_arready), 64'(1 << e));
            cyc(); req_arvalid[e] = 0; ARREADY = 1;
            #1 chk("t3_arid", 64'(ARID), 64'(e));
            cyc(); ARREADY = 0; RVALID = 1; RLAST = 1; RID = IDW'(e); RDATA = 64'(k);
            #1 chk("t3_rvalid", 64'(req_rvalid), 64'(1 << e));
            chk("t3_no_grant_in_data", 64'(req_arready), 0);
            cyc(); RVALID = 0; RLAST = 0;
        end
        req_arvalid = '0;

        // WRAP with len 2 is illegal: three local SLVERR beats, stalled by rready
        set_req(1, 1, 32'h3000, 4'd2, XSIZE_8, XBURST_WRAP);
        req_rready = 2'b10;
        #1 chk("t4_arready", 64'(req_arready), 2'b10);
        cyc(); req_arvalid[1] = 0;
        #1 chk("t4_state", 64'(dut.state), 64'(ERR));
        chk("t4_arvalid", 64'(ARVALID), 0);
        chk("t4_rvalid", 64'(req_rvalid), 2'b10);
        chk("t4_rresp", 64'(req_rresp), RESP_SLVERR);
        chk("t4_rdata", req_rdata, 0);
        chk("t4_rlast1", 64'(req_rlast), 0);
        cyc(); req_rready = 2'b00;
        #1 chk("t4_stall_rlast", 64'(req_rlast), 0);
        chk("t4_stall_rready", 64'(RREADY), 0);
        cyc(); req_rready = 2'b10;
        #1 chk("t4_rlast2", 64'(req_rlast), 0);
        cyc(); #1 chk("t4_rlast3", 64'(req_rlast), 1);
        cyc(); #1 chk("t4_idle", 64'(req_rvalid), 0);
        chk("t4_rrptr", 64'(dut.rr_ptr), 0);

        // reserved burst from req0 answered locally, then req1 goes to the slave
        set_req(0, 1, 32'h4000, 4'd0, XSIZE_8, XBURST_RESERVED);
        set_req(1, 1, 32'h4100, 4'd0, XSIZE_8, XBURST_INCR);
        req_rready = 2'b11;
        #1 chk("t5_grant0", 64'(req_arready), 2'b01);
        cyc(); req_arvalid[0] = 0;
        #1 chk("t5_err_rvalid", 64'(req_rvalid), 2'b01);
        chk("t5_err_rresp", 64'(req_rresp), RESP_SLVERR);
        chk("t5_err_rlast", 64'(req_rlast), 1);
        chk("t5_err_arvalid", 64'(ARVALID), 0);
        chk("t5_err_arready", 64'(req_arready), 0);
        cyc(); #1 chk("t5_grant1", 64'(req_arready), 2'b10);
        cyc(); req_arvalid[1] = 0; ARREADY = 1;
        #1 chk("t5_arvalid", 64'(ARVALID), 1);
        chk("t5_arid", 64'(ARID), 1);
        chk("t5_araddr", 64'(ARADDR), 32'h4100);
        cyc(); ARREADY = 0; RVALID = 1; RLAST = 1; RID = 1; RDATA = 64'hABCD; RRESP = RESP_OKAY;
        #1 chk("t5_rvalid", 64'(req_rvalid), 2'b10);
        chk("t5_rdata", req_rdata, 64'hABCD);
        chk("t5_rresp", 64'(req_rresp), RESP_OKAY);
        cyc(); RVALID = 0; RLAST = 0;
        #1 chk("t5_idle", 64'(dut.state), 64'(IDLE));
        chk("t5_rrptr", 64'(dut.rr_ptr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
